// File: rtl/ysyx_041461_lsu.sv
// Load/store unit: IDLE/REQ/WAIT bus FSM with byte-lane alignment and a response timeout.
// Define YSYX_041461_MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module ysyx_041461_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_ctrl,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_pc,
  output logic        stall_req,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic        req_wen,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic [63:0] out_pc,
  output logic        out_misalign,
  output logic        out_buserr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    ctrl_r;
  logic [2:0]    lane_r;
  logic [4:0]    rd_r;
  logic [63:0]   pc_r;
  logic          memop_s;
  logic          store_s;
  logic          imm_exc_s;

  function automatic logic [63:0] load_extend(input logic [3:0] ctrl, input logic [2:0] lane,
                                              input logic [63:0] rdata);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {lane, 3'b000};
    case (ctrl)
      4'd1:    res = {{56{sh[7]}}, sh[7:0]};
      4'd2:    res = {{48{sh[15]}}, sh[15:0]};
      4'd3:    res = {{32{sh[31]}}, sh[31:0]};
      4'd4:    res = rdata;
      4'd5:    res = {56'd0, sh[7:0]};
      4'd6:    res = {48'd0, sh[15:0]};
      4'd7:    res = {32'd0, sh[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] store_strb(input logic [3:0] ctrl, input logic [2:0] lane);
    logic [7:0] base;
    case (ctrl)
      4'd8:    base = 8'h01;
      4'd9:    base = 8'h03;
      4'd10:   base = 8'h0F;
      4'd11:   base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << lane;
  endfunction

  assign memop_s = (in_ctrl >= 4'd1) && (in_ctrl <= 4'd11);
  assign store_s = (in_ctrl >= 4'd8) && (in_ctrl <= 4'd11);

`ifdef YSYX_041461_MISALIGN_CHECK_EN
  logic misalign_r;

  function automatic logic misaligned(input logic [3:0] ctrl, input logic [2:0] low);
    logic res;
    case (ctrl)
      4'd2, 4'd6, 4'd9:  res = low[0];
      4'd3, 4'd7, 4'd10: res = |low[1:0];
      4'd4, 4'd11:       res = |low;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

  assign imm_exc_s    = (state_r == IDLE) && in_valid && memop_s && misaligned(in_ctrl, in_addr[2:0]);
  assign out_misalign = misalign_r;
`else
  assign imm_exc_s    = 1'b0;
  assign out_misalign = 1'b0;
`endif

  // Releasing the stall on the response cycle lets the pipeline advance on the same edge.
  assign stall_req = ~rst & in_valid & memop_s & ~((state_r == WAIT) & rsp_valid) & ~imm_exc_s;

  // Access FSM, bus request registers and write-back result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      ctrl_r     <= 4'd0;
      lane_r     <= 3'd0;
      rd_r       <= 5'd0;
      pc_r       <= 64'd0;
      req_valid  <= 1'b0;
      req_addr   <= 64'd0;
      req_wen    <= 1'b0;
      req_wdata  <= 64'd0;
      req_wstrb  <= 8'd0;
      out_valid  <= 1'b0;
      out_data   <= 64'd0;
      out_rd     <= 5'd0;
      out_pc     <= 64'h0000_0000_8000_0000;
      out_buserr <= 1'b0;
`ifdef YSYX_041461_MISALIGN_CHECK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      out_valid  <= 1'b0;
      out_buserr <= 1'b0;
`ifdef YSYX_041461_MISALIGN_CHECK_EN
      misalign_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (in_valid && !memop_s) begin
            out_valid <= 1'b1;
            out_data  <= in_addr;
            out_rd    <= in_rd;
            out_pc    <= in_pc;
          end else if (in_valid && imm_exc_s) begin
            out_valid <= 1'b1;
            out_data  <= 64'd0;
            out_rd    <= in_rd;
            out_pc    <= in_pc;
`ifdef YSYX_041461_MISALIGN_CHECK_EN
            misalign_r <= 1'b1;
`endif
          end else if (in_valid) begin
            state_r   <= REQ;
            cnt_r     <= {CW{1'b0}};
            ctrl_r    <= in_ctrl;
            lane_r    <= in_addr[2:0];
            rd_r      <= in_rd;
            pc_r      <= in_pc;
            req_valid <= 1'b1;
            req_addr  <= {in_addr[63:3], 3'b000};
            req_wen   <= store_s;
            req_wdata <= store_s ? (in_wdata << {in_addr[2:0], 3'b000}) : 64'd0;
            req_wstrb <= store_strb(in_ctrl, in_addr[2:0]);
          end
        end
        REQ: begin
          if (cnt_r == CNT_LAST) begin
            state_r    <= IDLE;
            req_valid  <= 1'b0;
            out_valid  <= 1'b1;
            out_buserr <= 1'b1;
            out_data   <= 64'd0;
            out_rd     <= rd_r;
            out_pc     <= pc_r;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (req_ready) begin
              state_r   <= WAIT;
              req_valid <= 1'b0;
            end
          end
        end
        WAIT: begin
          // A response on the final budget cycle still completes normally.
          if (rsp_valid) begin
            state_r   <= IDLE;
            out_valid <= 1'b1;
            out_data  <= load_extend(ctrl_r, lane_r, rsp_rdata);
            out_rd    <= rd_r;
            out_pc    <= pc_r;
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= IDLE;
            out_valid  <= 1'b1;
            out_buserr <= 1'b1;
            out_data   <= 64'd0;
            out_rd     <= rd_r;
            out_pc     <= pc_r;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_lsu.sv
// Self-checking bench for ysyx_041461_lsu: randomized instruction stream against a
// transaction-level model, plus directed literal cases.
module tb_ysyx_041461_lsu;

  localparam int TO = 255;
`ifdef YSYX_041461_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid;
  logic [3:0]  in_ctrl;
  logic [63:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_rd;
  logic        stall_req, req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        out_valid, out_misalign, out_buserr;
  logic [63:0] out_data, out_pc;
  logic [4:0]  out_rd;

  ysyx_041461_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd), .in_pc(in_pc), .stall_req(stall_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_pc(out_pc),
    .out_misalign(out_misalign), .out_buserr(out_buserr)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_outv = 0;
  logic [63:0] last_data;
  logic        last_mis, last_err;
  logic [63:0] obs_addr, obs_wdata;
  logic [7:0]  obs_strb;
  logic        obs_wen;
  int          obs_req_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: operation size / signedness and the resulting data.
  function automatic int op_bytes(input logic [3:0] c);
    case (c)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic bit op_signed(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd3);
  endfunction

  function automatic bit op_store(input logic [3:0] c);
    return (c >= 4'd8) && (c <= 4'd11);
  endfunction

  function automatic logic [63:0] exp_load(input logic [3:0] c, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int n, lane;
    logic [63:0] v, mask;
    n = op_bytes(c);
    lane = int'(addr % 64'd8);
    if (n == 8) return rdata;
    v = rdata >> (8 * lane);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (op_signed(c) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [3:0] c, input logic [63:0] addr);
    logic [15:0] s;
    s = ((16'd1 << op_bytes(c)) - 16'd1) << int'(addr % 64'd8);
    return s[7:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle output comparison against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_now;
    if (!rst) begin
      exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", 64'(out_valid), 64'(exp_now));
      if (out_valid) n_outv++;
      if (exp_now) begin
        e = exp_q.pop_front();
        if (out_valid) begin
          chk("out_data", out_data, e.data);
          chk("out_rd", 64'(out_rd), 64'(e.rd));
          chk("out_pc", out_pc, e.pc);
          chk("out_misalign", 64'(out_misalign), 64'(e.mis));
          chk("out_buserr", 64'(out_buserr), 64'(e.err));
          last_data = out_data;
          last_mis  = out_misalign;
          last_err  = out_buserr;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, "_req_wen"}, 64'(req_wen), 64'd0);
    chk({tag, "_req_wstrb"}, 64'(req_wstrb), 64'd0);
    chk({tag, "_req_addr"}, req_addr, 64'd0);
    chk({tag, "_req_wdata"}, req_wdata, 64'd0);
    chk({tag, "_stall"}, 64'(stall_req), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_misalign"}, 64'(out_misalign), 64'd0);
    chk({tag, "_out_buserr"}, 64'(out_buserr), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'h0000_0000_8000_0000);
  endtask

  // One idle pipeline slot; optional junk handshakes that must be ignored.
  task automatic bubble(input bit junk);
    in_valid  = 1'b0;
    in_ctrl   = 4'($urandom_range(0, 15));
    in_addr   = {$urandom, $urandom};
    req_ready = junk ? 1'($urandom) : 1'b0;
    rsp_valid = junk ? 1'($urandom) : 1'b0;
    rsp_rdata = {$urandom, $urandom};
    #4;
    chk("bubble_stall", 64'(stall_req), 64'd0);
    chk("bubble_req_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    req_ready = 1'b0;
    rsp_valid = 1'b0;
  endtask

  // Present one instruction (entered just after a negedge) and play the bus side.
  // rsp_dly < 0 means the bus never answers.
  task automatic do_instr(input logic [3:0] ctrl, input logic [63:0] addr, input logic [63:0] wdata,
                          input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
    int   n, nc;
    bit   mis;
    exp_t e;
    n   = op_bytes(ctrl);
    mis = MIS_EN && (n > 0) && ((addr % 64'(n)) != 64'd0);
    in_valid  = 1'b1;
    in_ctrl   = ctrl;
    in_addr   = addr;
    in_wdata  = wdata;
    in_rd     = 5'($urandom);
    in_pc     = {$urandom, $urandom};
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    e.rd = in_rd;
    e.pc = in_pc;
    e.mis = 1'b0;
    e.err = 1'b0;
    obs_req_cycles = 0;
    if (n == 0 || mis) begin
      #4;
      chk("pass_stall", 64'(stall_req), 64'd0);
      chk("pass_req_valid", 64'(req_valid), 64'd0);
      e.due = cyc + 1;
      e.data = (n == 0) ? addr : 64'd0;
      e.mis = mis;
      exp_q.push_back(e);
      @(negedge clk);
      return;
    end
    #4;
    chk("issue_stall", 64'(stall_req), 64'd1);
    chk("issue_req_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    nc = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      req_ready = (i == rdy_dly);
      rsp_valid = 1'($urandom);
      rsp_rdata = {$urandom, $urandom};
      #4;
      nc++;
      obs_req_cycles++;
      if (i == 0) begin
        obs_addr  = req_addr;
        obs_wdata = req_wdata;
        obs_strb  = req_wstrb;
        obs_wen   = req_wen;
      end
      chk("req_valid", 64'(req_valid), 64'd1);
      chk("req_addr", req_addr, addr & ~64'd7);
      chk("req_wen", 64'(req_wen), 64'(op_store(ctrl)));
      chk("req_wstrb", 64'(req_wstrb), op_store(ctrl) ? 64'(exp_strb(ctrl, addr)) : 64'd0);
      if (op_store(ctrl)) chk("req_wdata", req_wdata, wdata << (8 * int'(addr % 64'd8)));
      chk("req_stall", 64'(stall_req), 64'd1);
      @(negedge clk);
    end
    for (int j = 0; j <= TO; j++) begin
      req_ready = 1'($urandom);
      rsp_rdata = {$urandom, $urandom};
      if (rsp_dly >= 0 && j == rsp_dly) begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        #4;
        chk("rsp_stall", 64'(stall_req), 64'd0);
        chk("rsp_req_valid", 64'(req_valid), 64'd0);
        e.due = cyc + 1;
        e.data = op_store(ctrl) ? 64'd0 : exp_load(ctrl, addr, rdata);
        exp_q.push_back(e);
        @(negedge clk);
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        return;
      end
      rsp_valid = 1'b0;
      #4;
      nc++;
      chk("wait_stall", 64'(stall_req), 64'd1);
      chk("wait_req_valid", 64'(req_valid), 64'd0);
      if (nc == TO) begin
        e.due = cyc + 1;
        e.data = 64'd0;
        e.err = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        req_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    int n0;
    rst = 1'b1;
    in_valid = 1'b1; in_ctrl = 4'd4; in_addr = 64'h8000_0000; in_wdata = 64'd0;
    in_rd = 5'd0; in_pc = 64'd0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'd0;
    #12;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    bubble(1'b0);
    bubble(1'b0);

    // Signed byte load from the top lane of a word
    do_instr(4'd1, 64'h8000_0003, 64'd0, 0, 0, 64'h0000_0000_FF00_0000);
    bubble(1'b0);
    chk("lb_req_addr", obs_addr, 64'h8000_0000);
    chk("lb_out_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Halfword store into the upper lanes
    do_instr(4'd9, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 1, 1, 64'd0);
    bubble(1'b0);
    chk("sh_wen", 64'(obs_wen), 64'd1);
    chk("sh_wstrb", 64'(obs_strb), 64'hC0);
    chk("sh_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_out_data", last_data, 64'd0);

    // Slow ready then slow response
    n0 = n_outv;
    do_instr(4'd3, 64'h8000_0010, 64'd0, 3, 2, 64'h0123_4567_89AB_CDEF);
    bubble(1'b0);
    chk("slow_req_cycles", 64'(obs_req_cycles), 64'd4);
    chk("slow_out_pulses", 64'(n_outv - n0), 64'd1);
    chk("slow_lw_data", last_data, 64'hFFFF_FFFF_89AB_CDEF);

    // LD followed back-to-back by an ALU result
    n0 = n_outv;
    do_instr(4'd4, 64'h8000_0020, 64'd0, 0, 1, 64'h1122_3344_5566_7788);
    do_instr(4'd0, 64'h0000_0000_0000_0055, 64'd0, 0, 0, 64'd0);
    bubble(1'b0);
    chk("b2b_add_data", last_data, 64'h55);
    chk("b2b_pulses", 64'(n_outv - n0), 64'd2);

    // Word load at a 2-byte offset
    do_instr(4'd3, 64'h8000_0002, 64'd0, 0, 0, 64'hDEAD_BEEF_8765_4321);
    bubble(1'b0);
`ifdef YSYX_041461_MISALIGN_CHECK_EN
    chk("mis_flag", 64'(last_mis), 64'd1);
    chk("mis_no_req", 64'(obs_req_cycles), 64'd0);
`else
    chk("lw2_req_addr", obs_addr, 64'h8000_0000);
    chk("lw2_data", last_data, 64'hFFFF_FFFF_BEEF_8765);
    chk("lw2_no_mis", 64'(last_mis), 64'd0);
`endif

    // No response: timeout, then a stale response that must be ignored
    n0 = n_outv;
    do_instr(4'd4, 64'h8000_0040, 64'd0, 0, -1, 64'd0);
    rsp_valid = 1'b1;
    #4;
    chk("late_rsp_stall", 64'(stall_req), 64'd0);
    chk("late_rsp_req_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) bubble(1'b0);
    chk("timeout_buserr", 64'(last_err), 64'd1);
    chk("timeout_pulses", 64'(n_outv - n0), 64'd1);

    // Reset while waiting for a response
    n0 = n_outv;
    in_valid = 1'b1; in_ctrl = 4'd4; in_addr = 64'h8000_0080; req_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    req_ready = 1'b1;
    #4;
    chk("rstw_req_valid", 64'(req_valid), 64'd1);
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_wait");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) bubble(1'b1);
    chk("rstw_no_out", 64'(n_outv - n0), 64'd0);

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) bubble(1'b1);
      do_instr(4'($urandom_range(0, 15)), {32'd0, 16'h8000, 16'($urandom)},
               {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 4),
               {$urandom, $urandom});
    end
    bubble(1'b0);
    bubble(1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
